// File: rtl/router_pkg.sv
// router_pkg: shared packet field layout and destination helpers for the terminal source FIFO
package router_pkg;
    localparam int PCK_SZ  = 40;
    localparam int ROW_MSB = PCK_SZ - 9;
    localparam int ROW_LSB = PCK_SZ - 12;
    localparam int COL_MSB = PCK_SZ - 13;
    localparam int COL_LSB = PCK_SZ - 16;
    localparam int MODE_B  = PCK_SZ - 17;

    function automatic logic [3:0] dst_row(input logic [PCK_SZ-1:0] pkt);
        return pkt[ROW_MSB:ROW_LSB];
    endfunction

    function automatic logic [3:0] dst_col(input logic [PCK_SZ-1:0] pkt);
        return pkt[COL_MSB:COL_LSB];
    endfunction

    function automatic logic is_self(input logic [PCK_SZ-1:0] pkt, input logic [3:0] row, input logic [3:0] col);
        return (dst_row(pkt) == row) && (dst_col(pkt) == col);
    endfunction
endpackage

// File: rtl/router_term_src_fifo_if.sv
// router_term_src_fifo_if: terminal-side push port and router-side head/pop port
interface router_term_src_fifo_if #(
    parameter int PCK_SZ = 40,
    parameter int DEPTH  = 16
);
    logic                       push;
    logic [PCK_SZ-1:0]          din;
    logic                       full;
    logic                       popin;
    logic [PCK_SZ-1:0]          data_out_i_in;
    logic                       pndng_i_in;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       self_drop;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output push, din, popin,
        input  full, data_out_i_in, pndng_i_in, count, self_drop, overflow, underflow
    );

    modport slave (
        input  push, din, popin,
        output full, data_out_i_in, pndng_i_in, count, self_drop, overflow, underflow
    );
endinterface

// File: rtl/term_fifo_ram.sv
// term_fifo_ram: DEPTH x W storage, one synchronous write port, one asynchronous read port
module term_fifo_ram #(
    parameter int W     = 40,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    // write port; the array is deliberately never cleared
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/router_term_src_fifo.sv
// router_term_src_fifo: show-ahead injection FIFO in front of one router input, with self-address filter
module router_term_src_fifo
    import router_pkg::*;
#(
    parameter int PCK_SZ = router_pkg::PCK_SZ,
    parameter int DEPTH  = 16,
    parameter int MY_ROW = 0,
    parameter int MY_COL = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    router_term_src_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_self_drop;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_self;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [PCK_SZ-1:0] w_rdata;

    assign w_self  = is_self(bus.din, 4'(MY_ROW), 4'(MY_COL));
    assign w_full  = r_count == CW'(DEPTH);
    assign w_empty = r_count == '0;
    assign w_pop   = bus.popin && !w_empty;
    // a pop in the same cycle frees the slot, so full + pop + push is accepted
    assign w_push  = bus.push && !w_self && (!w_full || bus.popin);

    term_fifo_ram #(.W(PCK_SZ), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .i_we    (w_push && !reset),
        .i_waddr (r_wptr),
        .i_wdata (bus.din),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    // pointers, occupancy and sticky/pulse status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_self_drop <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count     <= r_count + CW'(w_push) - CW'(w_pop);
            r_self_drop <= bus.push && w_self;
            r_overflow  <= r_overflow || (bus.push && !w_self && w_full && !bus.popin);
            r_underflow <= r_underflow || (bus.popin && w_empty);
        end
    end

    assign bus.full          = w_full;
    assign bus.pndng_i_in    = !w_empty;
    assign bus.data_out_i_in = w_empty ? '0 : w_rdata;
    assign bus.count         = r_count;
    assign bus.self_drop     = r_self_drop;
    assign bus.overflow      = r_overflow;
    assign bus.underflow     = r_underflow;
endmodule

// File: tb/tb_router_term_src_fifo.sv
// tb_router_term_src_fifo: directed scenario tests for the terminal source FIFO
module tb_router_term_src_fifo;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;

    router_term_src_fifo_if #(.PCK_SZ(40), .DEPTH(16)) bus ();

    router_term_src_fifo #(.PCK_SZ(40), .DEPTH(16), .MY_ROW(2), .MY_COL(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // tag in the top byte and low bits; dst row [31:28], dst col [27:24], mode [23]
    function automatic logic [39:0] mk(input logic [3:0] row, input logic [3:0] col, input logic [7:0] tag);
        return {tag, row, col, 1'b0, 15'd0, tag};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.push = 1'b0;
        bus.popin = 1'b0;
        bus.din = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) begin
            bus.push = 1'b1;
            bus.din = mk(4'd1, 4'd2, 8'(i + 1));
            step();
        end
        bus.push = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        checks++; if (bus.pndng_i_in !== 1'b0) begin errors++; $display("FAIL reset_pndng got %b exp 0", bus.pndng_i_in); end
        checks++; if (bus.data_out_i_in !== 40'd0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.data_out_i_in); end
        checks++; if ({bus.full, bus.self_drop, bus.overflow, bus.underflow} !== 4'b0000)
            begin errors++; $display("FAIL reset_flags got %b exp 0000", {bus.full, bus.self_drop, bus.overflow, bus.underflow}); end
    endtask

    task automatic test_basic_order();
        logic [39:0] pk [3];
        pk[0] = mk(4'd1, 4'd2, 8'hA1);
        pk[1] = mk(4'd1, 4'd2, 8'hB2);
        pk[2] = mk(4'd1, 4'd2, 8'hC3);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.push = 1'b1;
            bus.din = pk[i];
            step();
            checks++; if (bus.count !== 5'(i + 1)) begin errors++; $display("FAIL basic_push_count got %0d exp %0d", bus.count, i + 1); end
            checks++; if (bus.data_out_i_in !== pk[0] || bus.pndng_i_in !== 1'b1)
                begin errors++; $display("FAIL basic_head_stable got %h/%b exp %h/1", bus.data_out_i_in, bus.pndng_i_in, pk[0]); end
        end
        bus.push = 1'b0;
        bus.popin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.count !== 5'(2 - i)) begin errors++; $display("FAIL basic_pop_count got %0d exp %0d", bus.count, 2 - i); end
            checks++; if (bus.data_out_i_in !== (i < 2 ? pk[i + 1] : 40'd0) || bus.pndng_i_in !== (i < 2))
                begin errors++; $display("FAIL basic_pop_head got %h/%b exp %h/%b", bus.data_out_i_in, bus.pndng_i_in, i < 2 ? pk[i + 1] : 40'd0, i < 2); end
        end
        bus.popin = 1'b0;
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL basic_no_underflow got %b exp 0", bus.underflow); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        fill16();
        checks++; if (bus.count !== 5'd16 || bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got %0d/%b exp 16/1", bus.count, bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %b exp 0", bus.overflow); end
        bus.push = 1'b1;
        bus.din = mk(4'd1, 4'd2, 8'd17);
        step();
        bus.push = 1'b0;
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", bus.overflow); end
        checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", bus.count); end
        checks++; if (bus.data_out_i_in !== mk(4'd1, 4'd2, 8'd1)) begin errors++; $display("FAIL ovf_head got %h exp %h", bus.data_out_i_in, mk(4'd1, 4'd2, 8'd1)); end
        step();
        step();
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow); end
        do_reset();
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset got %b exp 0", bus.overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [39:0] x;
        x = mk(4'd4, 4'd5, 8'h55);
        do_reset();
        fill16();
        bus.push = 1'b1;
        bus.popin = 1'b1;
        bus.din = x;
        step();
        bus.push = 1'b0;
        bus.popin = 1'b0;
        checks++; if (bus.count !== 5'd16 || bus.full !== 1'b1) begin errors++; $display("FAIL fpp_count got %0d/%b exp 16/1", bus.count, bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b exp 0", bus.overflow); end
        for (int i = 0; i < 16; i++) begin
            logic [39:0] e;
            e = (i < 15) ? mk(4'd1, 4'd2, 8'(i + 2)) : x;
            checks++; if (bus.data_out_i_in !== e) begin errors++; $display("FAIL fpp_drain[%0d] got %h exp %h", i, bus.data_out_i_in, e); end
            bus.popin = 1'b1;
            step();
            bus.popin = 1'b0;
        end
        checks++; if (bus.count !== 5'd0 || bus.pndng_i_in !== 1'b0) begin errors++; $display("FAIL fpp_empty got %0d/%b exp 0/0", bus.count, bus.pndng_i_in); end
    endtask

    task automatic test_self_drop();
        do_reset();
        bus.push = 1'b1;
        bus.din = mk(4'd2, 4'd3, 8'h77);
        step();
        bus.push = 1'b0;
        checks++; if (bus.self_drop !== 1'b1) begin errors++; $display("FAIL self_pulse got %b exp 1", bus.self_drop); end
        checks++; if (bus.count !== 5'd0 || bus.pndng_i_in !== 1'b0) begin errors++; $display("FAIL self_not_stored got %0d/%b exp 0/0", bus.count, bus.pndng_i_in); end
        step();
        checks++; if (bus.self_drop !== 1'b0) begin errors++; $display("FAIL self_one_cycle got %b exp 0", bus.self_drop); end
        bus.push = 1'b1;
        bus.din = mk(4'd2, 4'd4, 8'h78);
        step();
        bus.push = 1'b0;
        checks++; if (bus.self_drop !== 1'b0 || bus.count !== 5'd1) begin errors++; $display("FAIL self_col_differs got %b/%0d exp 0/1", bus.self_drop, bus.count); end
        do_reset();
        fill16();
        bus.push = 1'b1;
        bus.din = mk(4'd2, 4'd3, 8'h79);
        step();
        bus.push = 1'b0;
        checks++; if (bus.self_drop !== 1'b1 || bus.overflow !== 1'b0 || bus.count !== 5'd16)
            begin errors++; $display("FAIL self_full got %b/%b/%0d exp 1/0/16", bus.self_drop, bus.overflow, bus.count); end
    endtask

    task automatic test_underflow();
        logic [39:0] d;
        d = mk(4'd7, 4'd1, 8'hD4);
        do_reset();
        bus.popin = 1'b1;
        step();
        checks++; if (bus.underflow !== 1'b1 || bus.count !== 5'd0) begin errors++; $display("FAIL udf_set got %b/%0d exp 1/0", bus.underflow, bus.count); end
        bus.push = 1'b1;
        bus.din = d;
        step();
        bus.push = 1'b0;
        bus.popin = 1'b0;
        checks++; if (bus.count !== 5'd1 || bus.pndng_i_in !== 1'b1 || bus.data_out_i_in !== d)
            begin errors++; $display("FAIL udf_push got %0d/%b/%h exp 1/1/%h", bus.count, bus.pndng_i_in, bus.data_out_i_in, d); end
        step();
        checks++; if (bus.count !== 5'd1 || bus.underflow !== 1'b1) begin errors++; $display("FAIL udf_hold got %0d/%b exp 1/1", bus.count, bus.underflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.push = 1'b1;
            bus.din = mk(4'd1, 4'd2, 8'(i + 1));
            step();
        end
        checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL rmid_pre got %0d exp 5", bus.count); end
        reset = 1'b1;
        bus.din = mk(4'd1, 4'd2, 8'hEE);
        step();
        reset = 1'b0;
        bus.push = 1'b0;
        checks++; if (bus.count !== 5'd0 || bus.pndng_i_in !== 1'b0 || bus.data_out_i_in !== 40'd0)
            begin errors++; $display("FAIL rmid_clear got %0d/%b/%h exp 0/0/0", bus.count, bus.pndng_i_in, bus.data_out_i_in); end
        step();
        checks++; if (bus.count !== 5'd0 || bus.pndng_i_in !== 1'b0) begin errors++; $display("FAIL rmid_push_ignored got %0d/%b exp 0/0", bus.count, bus.pndng_i_in); end
    endtask

    initial begin
        reset = 1'b1;
        bus.push = 1'b0;
        bus.popin = 1'b0;
        bus.din = '0;
        test_reset();
        test_basic_order();
        test_fill_overflow();
        test_full_push_pop();
        test_self_drop();
        test_underflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_term_src_fifo.md
# router_term_src_fifo

Per-terminal injection buffer sitting directly upstream of one mesh-router input terminal. Accepts packets from the terminal agent/driver, stores them in a show-ahead FIFO, and presents the head packet to the router on `data_out_i_in`/`pndng_i_in`. The router consumes it with a one-cycle `popin` pulse. The block also drops illegal self-addressed packets and keeps sticky error flags for the bench and SVA.

## Interface
- `PCK_SZ`, 40: packet width; field positions come from the shared package.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `MY_ROW`, 0: mesh row of the attached terminal (4 bits).
- `MY_COL`, 0: mesh column of the attached terminal (4 bits).

- `clk`  in  1  single clock; everything samples on posedge.
- `reset`  in  1  synchronous, active-high.
- `push`  in  1  write request from the terminal agent.
- `din`  in  PCK_SZ  packet written on `push`.
- `full`  out  1  `count == DEPTH`.
- `popin`  in  1  router consumes the head packet.
- `data_out_i_in`  out  PCK_SZ  head packet; `'0` when empty.
- `pndng_i_in`  out  1  `count != 0`.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `self_drop`  out  1  one-cycle pulse when a self-addressed push is discarded.
- `overflow`  out  1  sticky; set by a push that was lost to a full FIFO.
- `underflow`  out  1  sticky; set by `popin` while empty.

## Operation
- Packet fields (package): `[PCK_SZ-9:PCK_SZ-12]` dst row, `[PCK_SZ-13:PCK_SZ-16]` dst col, `[PCK_SZ-17]` mode, remainder payload/next-jump.
- **Push accepted** when `push` is high, the destination is not self, and either `!full` or `popin` is high in the same cycle (full + pop + push is legal).
- **Self-addressed push** (dst row == `MY_ROW` and dst col == `MY_COL`):
  - not stored, regardless of `full`;
  - `self_drop` pulses next cycle;
  - `overflow` is unaffected.
- **Push lost to full:** `push` with `full` high, no `popin`, not self-addressed. Packet is dropped and `overflow` sets.
- **Pop** (`popin` high while `count != 0`): read pointer advances; the next head is visible the following cycle.
- **Pop while empty:** ignored; `underflow` sets. A simultaneous push to an empty FIFO is still accepted, but does not satisfy that same-cycle pop.
- **Pointers:** `log2(DEPTH)`-bit, wrap naturally.
- **Count update:** `count` += accepted push, −= valid pop; a simultaneous push and pop leaves it unchanged.
- **Ordering:** strict FIFO order; no reordering or broadcast.

## Timing
- **Reset values:** `count`=0, `pndng_i_in`=0, `data_out_i_in`='0, `full`=0, `self_drop`=0, `overflow`=0, `underflow`=0. Pointers are reset to 0; RAM contents are not cleared.
- **Reset mid-operation:** all stored packets are discarded from the next cycle. `push`/`popin` sampled in the reset cycle are ignored.
- **Push-to-visible latency:** 1 cycle. A push at edge N into an empty FIFO gives `pndng_i_in`=1 and head = `din` after edge N.
- **Pop-to-advance:** 1 cycle. After the `popin` edge, `data_out_i_in` shows the next entry, or `'0` with `pndng_i_in`=0 if the FIFO emptied.
- **Output paths:**
  - `data_out_i_in`, `pndng_i_in`, `full` are decoded from registered state only; there is no combinational path from `push`/`popin`/`din`.
  - `self_drop` is registered.
- **Router progress:** any packet at the head must be popped within 128 cycles. That check is the router's responsibility; this block only holds the head stable until `popin`.
- **Head stability:** `data_out_i_in` does not change while `pndng_i_in`=1 and `popin`=0, even under concurrent pushes.

## Structure
- **`router_pkg`** holds:
  - `PCK_SZ` default;
  - field MSB/LSB localparams;
  - `dst_row()`, `dst_col()`, `is_self(pkt,row,col)` functions.
  
  The SVA and scoreboard share the same package.
- **Sub-module `term_fifo_ram`:** `DEPTH`×`PCK_SZ`, one write port, one asynchronous read port, no reset on the array.
- **Top level** (pointers, count, flags, self filter) stays in `router_term_src_fifo`.

## Test plan
- **Basic order:** reset, push A, B, C (dst 1,2) on consecutive cycles, then `popin` each cycle → head A, B, C in order; `pndng_i_in` falls the cycle after the third pop; `count` reads 3,2,1,0.
- **Fill and overflow:** push 17 packets with `DEPTH`=16 and no pops → `full`=1 at `count`=16; 17th packet lost; `overflow`=1 and stays set until reset.
- **Full + simultaneous push/pop:** → `count` stays 16; the new packet is stored; `overflow` stays 0.
- **Self-address drop:** `MY_ROW`=2, `MY_COL`=3; push a packet with dst (2,3) → `self_drop` pulses one cycle; `count` unchanged; `pndng_i_in` stays 0.
- **Underflow:** `popin` while empty → `underflow`=1 and `count` stays 0. The same cycle with `push` → packet visible next cycle, `count`=1.
- **Reset mid-operation:** with 5 packets queued, assert `reset` for one cycle alongside `push` → `count`=0, `pndng_i_in`=0, `data_out_i_in`='0; the pushed packet is not stored.
